// File: rtl/prim_sram_rsp_pkg.sv
// rtl/prim_sram_rsp_pkg.sv - shared constants and helper functions for the SRAM responder
package prim_sram_rsp_pkg;

    // Bit positions inside the 2-bit rerror response field
    localparam int ErrAddrIdx = 0;
    localparam int ErrParIdx  = 1;

    // Widest data word the helpers accept; callers zero-extend into it
    localparam int MaxDw = 1024;
    localparam int MaxNb = MaxDw / 8;

    // Even parity of every byte; bit b covers data[8*b +: 8]
    function automatic logic [MaxNb-1:0] par_bytes(input logic [MaxDw-1:0] data);
        logic [MaxNb-1:0] par;
        par = '0;
        for (int b = 0; b < MaxNb; b++) begin
            par[b] = ^data[b*8 +: 8];
        end
        return par;
    endfunction

    // Unsigned full-width compare of a word address against the implemented depth
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/prim_sram_rsp_pipe.sv
// rtl/prim_sram_rsp_pipe.sv - fixed-latency delay line with per-stage valid flag
module prim_sram_rsp_pipe #(
    parameter int Width  = 8,
    parameter int Stages = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);

    logic [Stages-1:0] valid_q;
    logic [Width-1:0]  data_q [Stages];

    // Shift valid and payload one stage per cycle; payload is zero whenever its stage is empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < Stages; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < Stages; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[Stages-1];
    assign out_data  = data_q[Stages-1];

endmodule

// File: rtl/prim_sram_responder.sv
// rtl/prim_sram_responder.sv - flop-based SRAM endpoint with fixed read latency; optional byte parity via SRAM_RSP_PARITY_EN
module prim_sram_responder
    import prim_sram_rsp_pkg::*;
#(
    parameter int SramDw      = 32,
    parameter int SramAw      = 12,
    parameter int Depth       = 1024,
    parameter int ReadLatency = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sram_req,
    input  logic              sram_write,
    input  logic [SramAw-1:0] sram_addr,
    input  logic [SramDw-1:0] sram_wdata,
`ifdef SRAM_RSP_PARITY_EN
    input  logic [SramDw/8-1:0] wr_par_flip_i,
`endif
    output logic              sram_rvalid,
    output logic [SramDw-1:0] sram_rdata,
    output logic [1:0]        sram_rerror
);

    localparam int Nb   = SramDw / 8;
    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [SramDw-1:0] mem [Depth];
    logic              addr_ok;
    logic [IdxW-1:0]   idx;
    logic              wr_en;
    logic              rd_en;
    logic [SramDw-1:0] rd_data;
    logic [1:0]        rd_err;

    assign addr_ok = in_range(64'(sram_addr), 64'(Depth));
    assign idx     = sram_addr[IdxW-1:0];
    assign wr_en   = sram_req & sram_write & addr_ok;
    assign rd_en   = sram_req & ~sram_write;

    // Data storage: cleared by reset, updated on in-range writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= sram_wdata;
        end
    end

`ifdef SRAM_RSP_PARITY_EN
    logic [Nb-1:0] par_mem [Depth];

    // Parity storage: even parity per byte, optionally corrupted by the flip mask
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                par_mem[i] <= '0;
            end
        end else if (wr_en) begin
            par_mem[idx] <= Nb'(par_bytes(MaxDw'(sram_wdata))) ^ wr_par_flip_i;
        end
    end
`endif

    // Read in the acceptance cycle; out-of-range reads return zero data and the address error only
    always_comb begin
        rd_data = '0;
        rd_err  = '0;
        if (addr_ok) begin
            rd_data = mem[idx];
`ifdef SRAM_RSP_PARITY_EN
            rd_err[ErrParIdx] = |(par_bytes(MaxDw'(mem[idx])) ^ MaxNb'(par_mem[idx]));
`endif
        end else begin
            rd_err[ErrAddrIdx] = 1'b1;
        end
    end

    prim_sram_rsp_pipe #(
        .Width  (SramDw + 2),
        .Stages (ReadLatency)
    ) u_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (rd_en),
        .in_data   ({rd_err, rd_data}),
        .out_valid (sram_rvalid),
        .out_data  ({sram_rerror, sram_rdata})
    );

endmodule
